// File: rtl/xadac_vrequant_unit_if.sv
// ============================================================================
// xadac_vrequant_unit_if -- request/response bundle for the requantiser | rev 1.0
// ============================================================================
`default_nettype none

interface xadac_vrequant_unit_if #(
  parameter int NrLanes  = 4,
  parameter int SumWidth = 32,
  parameter int IdWidth  = 4,
  parameter int XLEN     = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic [IdWidth-1:0]           req_id;
  logic [7:0]                   req_imm;
  logic [XLEN-1:0]              req_rs1;
  logic [NrLanes*SumWidth-1:0]  req_vs1;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [IdWidth-1:0]           resp_id;
  logic [XLEN-1:0]              resp_rd;
  logic [NrLanes*SumWidth-1:0]  resp_vd;

  modport master (
    output req_valid, req_id, req_imm, req_rs1, req_vs1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_rd, resp_vd
  );

  modport slave (
    input  req_valid, req_id, req_imm, req_rs1, req_vs1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_rd, resp_vd
  );
endinterface

`default_nettype wire

// File: rtl/xadac_vrequant_unit.sv
// ============================================================================
// xadac_vrequant_unit -- serial ReLU / rounding shift / saturate to int8 | rev 1.0
// ============================================================================
`default_nettype none

module xadac_vrequant_unit #(
  parameter int NrLanes  = 4,
  parameter int SumWidth = 32,
  parameter int OutWidth = 8,
  parameter int IdWidth  = 4,
  parameter int XLEN     = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  xadac_vrequant_unit_if.slave   bus
);

  localparam int NW = $clog2(NrLanes + 1);
  localparam logic signed [SumWidth:0] c_sat_max = (SumWidth+1)'(2**(OutWidth-1) - 1);
  localparam logic signed [SumWidth:0] c_sat_min = -((SumWidth+1)'(2**(OutWidth-1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [IdWidth-1:0]           r_id;
  logic [NW-1:0]                r_n;
  logic [NW-1:0]                r_k;
  logic [4:0]                   r_sh;
  logic                         r_relu;
  logic [NrLanes*SumWidth-1:0]  r_vs;
  logic [XLEN-1:0]              r_rd;

  logic [NW-1:0]                w_n_clamp;
  logic                         w_accept;
  logic                         w_last;
  logic signed [SumWidth-1:0]   w_lane;
  logic signed [SumWidth-1:0]   w_relu;
  logic signed [SumWidth:0]     w_ext;
  logic signed [SumWidth:0]     w_rnd;
  logic signed [SumWidth:0]     w_sum;
  logic signed [SumWidth:0]     w_shr;
  logic [OutWidth-1:0]          w_sat;
  logic                         w_unused;

  assign w_unused  = ^bus.req_rs1[XLEN-1:6];
  assign w_n_clamp = (bus.req_imm > 8'(NrLanes)) ? NW'(NrLanes) : bus.req_imm[NW-1:0];
  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_last    = (r_k == r_n - NW'(1));

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < NrLanes; i++) begin
      if (r_k == NW'(i)) w_lane = r_vs[i*SumWidth +: SumWidth];
    end
  end

  // One extra bit of headroom keeps s + 2^(sh-1) from wrapping at the positive limit.
  assign w_relu = (r_relu && w_lane[SumWidth-1]) ? '0 : w_lane;
  assign w_ext  = {w_relu[SumWidth-1], w_relu};
  assign w_rnd  = (r_sh == 5'd0) ? '0 : ((SumWidth+1)'(1) << (r_sh - 5'd1));
  assign w_sum  = w_ext + w_rnd;
  assign w_shr  = w_sum >>> r_sh;

  always_comb begin
    w_sat = w_shr[OutWidth-1:0];
    if (w_shr > c_sat_max)      w_sat = c_sat_max[OutWidth-1:0];
    else if (w_shr < c_sat_min) w_sat = c_sat_min[OutWidth-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_state_next = (w_n_clamp != '0) ? RUN : RESP;
      RUN:     if (w_last)        w_state_next = RESP;
      RESP:    if (bus.resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_sh    <= '0;
      r_relu  <= 1'b0;
      r_vs    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id   <= bus.req_id;
        r_n    <= w_n_clamp;
        r_sh   <= bus.req_rs1[4:0];
        r_relu <= bus.req_rs1[5];
        r_vs   <= bus.req_vs1;
        r_k    <= '0;
        r_rd   <= '0;
      end else if (r_state == RUN) begin
        for (int i = 0; i < NrLanes; i++) begin
          if (r_k == NW'(i)) r_rd[i*OutWidth +: OutWidth] <= w_sat;
        end
        if (!w_last) r_k <= r_k + NW'(1);
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE) && !rst;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_id    = r_id;
  assign bus.resp_rd    = r_rd;
  assign bus.resp_vd    = '0;

endmodule

`default_nettype wire

// File: tb/tb_xadac_vrequant_unit.sv
// ============================================================================
// tb_xadac_vrequant_unit -- directed bench with arithmetic reference model | rev 1.0
// ============================================================================
`default_nettype none

module tb_xadac_vrequant_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   expect_active = 1'b0;
  logic [31:0] exp_rd;
  logic [3:0]  exp_id;

  xadac_vrequant_unit_if bus ();

  xadac_vrequant_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Round-half-up as floor((s + d/2) / d) using ordinary integer division.
  function automatic logic [31:0] model(input logic [127:0] vs, input int n,
                                        input int sh, input bit relu);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      longint s, d, num, t;
      logic [63:0] tb;
      if (i < n) begin
        s = longint'($signed(vs[32*i +: 32]));
        if (relu && s < 0) s = 0;
        d = longint'(1) << sh;
        if (sh == 0) t = s;
        else begin
          num = s + d / 2;
          t = num / d;
          if ((num % d) != 0 && num < 0) t = t - 1;
        end
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        tb = 64'(t);
        r[8*i +: 8] = tb[7:0];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("resp_vd_zero", 64'(bus.resp_vd), 64'd0);
      if (bus.resp_valid) begin
        if (!expect_active) chk("unexpected_resp_valid", 64'(bus.resp_valid), 64'd0);
        else begin
          chk("resp_rd", 64'(bus.resp_rd), 64'(exp_rd));
          chk("resp_id", 64'(bus.resp_id), 64'(exp_id));
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic do_txn(input logic [3:0] id, input logic [7:0] imm, input logic [31:0] rs1,
                        input logic [127:0] vs, input int hold, output logic [31:0] got);
    int n, lat;
    n = (imm > 4) ? 4 : int'(imm);
    wait_ready();
    exp_rd = model(vs, n, int'(rs1[4:0]), rs1[5]);
    exp_id = id;
    expect_active = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_id = id;
    bus.req_imm = imm;
    bus.req_rs1 = rs1;
    bus.req_vs1 = vs;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_id = 4'($urandom);
    bus.req_imm = 8'($urandom);
    bus.req_rs1 = $urandom;
    bus.req_vs1 = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'((n == 0) ? 1 : n + 1));
    got = bus.resp_rd;
    if (hold > 0) begin
      bus.resp_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
        bus.req_valid = (c == 2);
        @(posedge clk); #1;
        chk("bp_valid", 64'(bus.resp_valid), 64'd1);
        chk("bp_rd_stable", 64'(bus.resp_rd), 64'(got));
        chk("bp_id_stable", 64'(bus.resp_id), 64'(id));
        chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = 1'b0;
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    expect_active = 1'b0;
    chk("post_hs_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_hs_ready", 64'(bus.req_ready), 64'd1);
  endtask

  localparam logic [127:0] LANES_A = {32'hFFFFFF38, 32'd1000, 32'hFFFFFFFB, 32'd300};
  localparam logic [127:0] LANES_B = {32'hFFFFFF7F, 32'hFFFFFF80, 32'd128, 32'd127};
  localparam logic [127:0] LANES_C = {32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF};

  initial begin
    logic [31:0] got;
    bus.req_valid = 1'b0;
    bus.req_id = '0;
    bus.req_imm = '0;
    bus.req_rs1 = '0;
    bus.req_vs1 = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_rd", 64'(bus.resp_rd), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    do_txn(4'd5, 8'd4, 32'h2, LANES_A, 0, got);
    chk("lit_round_sat", 64'(got), 64'hCE7FFF4B);
    do_txn(4'd6, 8'd4, 32'h22, LANES_A, 0, got);
    chk("lit_relu", 64'(got), 64'h007F004B);
    do_txn(4'd7, 8'd2, 32'h2, LANES_A, 0, got);
    chk("lit_n2", 64'(got), 64'h0000FF4B);
    do_txn(4'd8, 8'd9, 32'hFFFFFFC2, LANES_A, 0, got);
    chk("lit_n9", 64'(got), 64'hCE7FFF4B);
    do_txn(4'd1, 8'd0, 32'h2, LANES_A, 0, got);
    chk("lit_n0", 64'(got), 64'h0);
    do_txn(4'd2, 8'd4, 32'h0, LANES_B, 0, got);
    chk("lit_sh0", 64'(got), 64'h80807F7F);
    do_txn(4'd3, 8'd4, 32'hFFFFFFDF, LANES_C, 0, got);
    chk("lit_sh31", 64'(got), 64'h0000FF01);
    do_txn(4'd9, 8'd4, 32'h2, LANES_A, 7, got);
    chk("lit_backpressure", 64'(got), 64'hCE7FFF4B);
    do_txn(4'd10, 8'd3, 32'h1, LANES_B, 0, got);

    // Abandon a transaction after lane 0 has been written.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_id = 4'd12;
    bus.req_imm = 8'd4;
    bus.req_rs1 = 32'h2;
    bus.req_vs1 = LANES_A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_resp_rd", 64'(bus.resp_rd), 64'd0);
    chk("midrst_resp_id", 64'(bus.resp_id), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_idle_ready", 64'(bus.req_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    do_txn(4'd13, 8'd4, 32'h22, LANES_A, 0, got);
    chk("lit_after_rst", 64'(got), 64'h007F004B);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
